pacman_motion: RTL and testbench

Moves Pac-Man through the maze once per video frame and produces the `pX`/`pY` top-left position that the collision/scoring FSM and the sprite renderer consume. It buffers the player's last WASD direction and applies it at the next tile-aligned position where the maze allows the turn. Wall lookups go to the external maze wall ROM through a 1-cycle-latency query port. The block sits directly upstream of the game-state logic.

---
 rtl/pacman_pkg.sv | 62 ++++++
 rtl/pacman_motion_tick_sync.sv | 43 ++++
 rtl/pacman_motion.sv | 246 ++++++++++++++++++++++++
 tb/tb_pacman_motion.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacman_pkg
// Description : Shared types, keycodes, maze defaults and direction helpers
//               for Pac-Man and the ghost movers.
// Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

  // Heading encoding: opposite directions differ only in bit 1.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_QRY_NEXT = 3'd1,
    ST_CHK_NEXT = 3'd2,
    ST_QRY_CUR  = 3'd3,
    ST_CHK_CUR  = 3'd4,
    ST_MOVE     = 3'd5
  } state_t;

  // USB HID keycodes for W/A/S/D.
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // Maze geometry shared by every mover.
  localparam int PKG_TILE   = 16;
  localparam int PKG_MAZE_W = 40;
  localparam int PKG_MAZE_H = 30;

  // Unit step along a heading: each field is -1, 0 or +1.
  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } delta_t;

  function automatic dir_t reverse(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  function automatic delta_t step(input dir_t d);
    delta_t r;
    r = '{dx: 2'sd0, dy: 2'sd0};
    case (d)
      DIR_UP:    r.dy = -2'sd1;
      DIR_LEFT:  r.dx = -2'sd1;
      DIR_DOWN:  r.dy = 2'sd1;
      DIR_RIGHT: r.dx = 2'sd1;
      default:   r = '{dx: 2'sd0, dy: 2'sd0};
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pacman_motion_tick_sync.sv
`default_nettype none
// ============================================================================
// Module      : tick_sync
// Description : Two-flop synchronizer for the raw vsync level followed by a
//               rising-edge detector producing a one-cycle pulse.
// Ports       : Clk, Reset    - clock / synchronous active-high reset
//               tick_in       - asynchronous vsync level
//               tick_pulse    - one-cycle pulse on each synchronized rise
// Revision    : 1.0 - initial release
// ============================================================================
module tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic tick_in,
  output logic tick_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q,  edge_d;

  always_comb begin
    sync1_d = tick_in;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

  assign tick_pulse = sync2_q & ~edge_q;

endmodule
`default_nettype wire

// File: rtl/pacman_motion.sv
`default_nettype none
// ============================================================================
// Module      : pacman_motion
// Description : Per-frame Pac-Man mover. Buffers the last WASD direction and
//               applies it at the next tile-aligned position where the maze
//               permits, querying the wall ROM (1-cycle latency) as needed.
// Ports       : Clk, Reset       - clock / synchronous active-high reset
//               frame_tick       - raw vsync level (edge-detected inside)
//               enable           - game running; low freezes motion
//               keycode[7:0]     - USB keycode
//               wq_col/wq_row    - wall ROM query tile
//               wall             - ROM answer for previous-cycle query
//               pX/pY[9:0]       - top-left position in pixels
//               dir[1:0]         - heading (UP/LEFT/DOWN/RIGHT = 0..3)
//               moving           - last update moved Pac-Man
//               busy             - update in progress
// Revision    : 1.0 - initial release
// ============================================================================
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int TILE    = PKG_TILE,
  parameter int SPEED   = 2,
  parameter int MAZE_W  = PKG_MAZE_W,
  parameter int MAZE_H  = PKG_MAZE_H,
  parameter int START_X = 304,
  parameter int START_Y = 368
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [7:0] keycode,
  output logic [5:0] wq_col,
  output logic [4:0] wq_row,
  input  logic       wall,
  output logic [9:0] pX,
  output logic [9:0] pY,
  output logic [1:0] dir,
  output logic       moving,
  output logic       busy
);

  localparam int         TILE_LOG2 = $clog2(TILE);
  localparam logic [9:0] X_MAX     = 10'((MAZE_W - 1) * TILE);
  localparam logic [9:0] STEP_PX   = 10'(SPEED);
  localparam logic [5:0] COL_MAX   = 6'(MAZE_W - 1);
  localparam logic [4:0] ROW_MAX   = 5'(MAZE_H - 1);

  logic tick_pulse;

  tick_sync u_tick_sync (
    .Clk        (Clk),
    .Reset      (Reset),
    .tick_in    (frame_tick),
    .tick_pulse (tick_pulse)
  );

  state_t     state_q,     state_d;
  logic [9:0] px_q,        px_d;
  logic [9:0] py_q,        py_d;
  dir_t       dir_q,       dir_d;
  dir_t       buf_dir_q,   buf_dir_d;
  logic       buf_valid_q, buf_valid_d;
  dir_t       cand_q,      cand_d;
  logic       moving_q,    moving_d;
  logic       clamp_q,     clamp_d;
  logic [5:0] wq_col_q,    wq_col_d;
  logic [4:0] wq_row_q,    wq_row_d;

  logic       aligned;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  dir_t       qdir;
  delta_t     qdelta;
  logic [5:0] ahead_col;
  logic [4:0] ahead_row;
  logic       ahead_clamp;
  logic       query_en;
  logic       key_hit;
  dir_t       key_dir;
  logic       blocked;

  assign aligned = (px_q[TILE_LOG2-1:0] == '0) && (py_q[TILE_LOG2-1:0] == '0);
  assign cur_col = 6'(px_q >> TILE_LOG2);
  assign cur_row = 5'(py_q >> TILE_LOG2);

  // The only query in QRY_NEXT is for the buffered turn; all others probe
  // straight ahead.
  assign qdir   = (state_q == ST_QRY_NEXT) ? buf_dir_q : dir_q;
  assign qdelta = step(qdir);

  // Tile ahead: columns wrap through the tunnel, rows clamp and the clamp
  // is remembered so the following check treats it as a wall.
  always_comb begin
    ahead_col   = cur_col;
    ahead_row   = cur_row;
    ahead_clamp = 1'b0;
    if (qdelta.dx < 2'sd0)
      ahead_col = (cur_col == 6'd0) ? COL_MAX : cur_col - 6'd1;
    else if (qdelta.dx > 2'sd0)
      ahead_col = (cur_col == COL_MAX) ? 6'd0 : cur_col + 6'd1;
    if (qdelta.dy < 2'sd0) begin
      if (cur_row == 5'd0) ahead_clamp = 1'b1;
      else                 ahead_row   = cur_row - 5'd1;
    end else if (qdelta.dy > 2'sd0) begin
      if (cur_row == ROW_MAX) ahead_clamp = 1'b1;
      else                    ahead_row   = cur_row + 5'd1;
    end
  end

  always_comb begin
    key_hit = 1'b1;
    key_dir = DIR_UP;
    case (keycode)
      KEY_W:   key_dir = DIR_UP;
      KEY_A:   key_dir = DIR_LEFT;
      KEY_S:   key_dir = DIR_DOWN;
      KEY_D:   key_dir = DIR_RIGHT;
      default: key_hit = 1'b0;
    endcase
  end

  assign blocked = wall | clamp_q;

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    dir_d       = dir_q;
    buf_dir_d   = buf_dir_q;
    buf_valid_d = buf_valid_q;
    cand_d      = cand_q;
    moving_d    = moving_q;
    query_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick_pulse && enable) state_d = ST_QRY_NEXT;
      end
      ST_QRY_NEXT: begin
        if (buf_valid_q && (buf_dir_q == reverse(dir_q))) begin
          // Reversal is always legal: the tile behind was just vacated.
          dir_d       = buf_dir_q;
          buf_valid_d = 1'b0;
          state_d     = ST_MOVE;
        end else if (buf_valid_q && (buf_dir_q != dir_q) && aligned) begin
          query_en = 1'b1;
          cand_d   = buf_dir_q;
          state_d  = ST_CHK_NEXT;
        end else begin
          state_d = ST_QRY_CUR;
        end
      end
      ST_CHK_NEXT: begin
        if (!blocked) begin
          // Adopt the direction that was actually checked; a newer key
          // pressed meanwhile stays pending.
          dir_d = cand_q;
          if (buf_dir_q == cand_q) buf_valid_d = 1'b0;
          state_d = ST_MOVE;
        end else begin
          state_d = ST_QRY_CUR;
        end
      end
      ST_QRY_CUR: begin
        if (!aligned) begin
          state_d = ST_MOVE;
        end else begin
          query_en = 1'b1;
          state_d  = ST_CHK_CUR;
        end
      end
      ST_CHK_CUR: begin
        if (!blocked) begin
          state_d = ST_MOVE;
        end else begin
          moving_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_MOVE: begin
        case (dir_q)
          DIR_LEFT:  px_d = (px_q == 10'd0)  ? X_MAX : px_q - STEP_PX;
          DIR_RIGHT: px_d = (px_q == X_MAX)  ? 10'd0 : px_q + STEP_PX;
          DIR_UP:    py_d = py_q - STEP_PX;
          DIR_DOWN:  py_d = py_q + STEP_PX;
          default:   px_d = px_q;
        endcase
        moving_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Key writes come last so a press in the same cycle as a clear wins.
    if (key_hit) begin
      buf_dir_d   = key_dir;
      buf_valid_d = 1'b1;
    end
  end

  // Query address is formed from registered state and presented during the
  // Q state itself, so the ROM answer lines up with the following CHK state.
  assign wq_col   = query_en ? ahead_col : wq_col_q;
  assign wq_row   = query_en ? ahead_row : wq_row_q;
  assign wq_col_d = wq_col;
  assign wq_row_d = wq_row;
  assign clamp_d  = query_en ? ahead_clamp : clamp_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      px_q        <= 10'(START_X);
      py_q        <= 10'(START_Y);
      dir_q       <= DIR_LEFT;
      buf_dir_q   <= DIR_LEFT;
      buf_valid_q <= 1'b0;
      cand_q      <= DIR_LEFT;
      moving_q    <= 1'b0;
      clamp_q     <= 1'b0;
      wq_col_q    <= 6'd0;
      wq_row_q    <= 5'd0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      dir_q       <= dir_d;
      buf_dir_q   <= buf_dir_d;
      buf_valid_q <= buf_valid_d;
      cand_q      <= cand_d;
      moving_q    <= moving_d;
      clamp_q     <= clamp_d;
      wq_col_q    <= wq_col_d;
      wq_row_q    <= wq_row_d;
    end
  end

  assign pX     = px_q;
  assign pY     = py_q;
  assign dir    = dir_q;
  assign moving = moving_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pacman_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_pacman_motion
// Description : Directed self-checking bench for pacman_motion with a
//               registered wall-ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_motion;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       wall = 1'b0;
    logic [5:0] wq_col;
    logic [4:0] wq_row;
    logic [9:0] pX, pY;
    logic [1:0] dir;
    logic       moving, busy;

    bit walls [0:39][0:29];
    int errors = 0;
    int checks = 0;
    int lat, nb;
    bit seen;

    pacman_motion dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .enable     (enable),
        .keycode    (keycode),
        .wq_col     (wq_col),
        .wq_row     (wq_row),
        .wall       (wall),
        .pX         (pX),
        .pY         (pY),
        .dir        (dir),
        .moving     (moving),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    // Wall ROM model: answers one cycle after the address is presented.
    always @(posedge Clk)
        wall <= (wq_col < 6'd40 && wq_row < 5'd30) ? walls[wq_col][wq_row] : 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_walls();
        foreach (walls[c, r]) walls[c][r] = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1; enable = 1'b1; keycode = 8'h00; frame_tick = 1'b0;
        clear_walls();
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        @(negedge Clk);
        keycode = 8'h00;
        @(negedge Clk);
    endtask

    // One frame: lat = negedges until busy seen (0 = never), n = busy cycles.
    task automatic do_tick(output int l, output int n);
        l = 0; n = 0;
        frame_tick = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge Clk);
            if (k == 4) frame_tick = 1'b0;
            if (busy) begin
                if (l == 0) l = k;
                n++;
            end
        end
    endtask

    task automatic ticks(input int cnt);
        int l, n;
        for (int i = 0; i < cnt; i++) do_tick(l, n);
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_pX", pX, 10'd304);
        chk("rst_pY", pY, 10'd368);
        chk("rst_dir", dir, 2'd1);
        chk("rst_moving", moving, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wq_col", wq_col, 6'd0);
        chk("rst_wq_row", wq_row, 5'd0);

        // ---------------- LEFT held, 8 frames ----------------
        keycode = 8'h04;
        do_tick(lat, nb);
        chk("t1_latency", lat, 3);
        chk("t1_busy_cycles", nb, 4);
        chk("t1_pX", pX, 10'd302);
        chk("t1_wq_col", wq_col, 6'd18);
        chk("t1_wq_row", wq_row, 5'd23);
        chk("t1_moving", moving, 1'b1);
        do_tick(lat, nb);
        chk("t1_midtile_busy", nb, 3);
        ticks(6);
        keycode = 8'h00;
        chk("t1_8_pX", pX, 10'd288);
        chk("t1_8_pY", pY, 10'd368);
        chk("t1_8_dir", dir, 2'd1);
        chk("t1_8_moving", moving, 1'b1);

        // ---------------- reversal mid-tile ----------------
        do_reset();
        keycode = 8'h04;
        ticks(3);
        keycode = 8'h00;
        chk("rev_pre_pX", pX, 10'd298);
        press(8'h07);
        do_tick(lat, nb);
        chk("rev_dir", dir, 2'd3);
        chk("rev_pX", pX, 10'd300);
        chk("rev_busy_cycles", nb, 2);
        chk("rev_wq_col_held", wq_col, 6'd18);
        chk("rev_bufvalid", dut.buf_valid_q, 1'b0);

        // ---------------- RIGHT into wall at col 20 ----------------
        ticks(2);
        chk("rw_pre_pX", pX, 10'd304);
        walls[20][23] = 1'b1;
        do_tick(lat, nb);
        chk("rw_pX", pX, 10'd304);
        chk("rw_moving", moving, 1'b0);
        chk("rw_busy_cycles", nb, 3);
        chk("rw_wq_col", wq_col, 6'd20);
        chk("rw_wq_row", wq_row, 5'd23);
        do_tick(lat, nb);
        chk("rw2_pX", pX, 10'd304);
        chk("rw2_moving", moving, 1'b0);
        chk("rw2_busy_cycles", nb, 3);

        // ---------------- buffered UP turn ----------------
        do_reset();
        keycode = 8'h04;
        ticks(8);
        keycode = 8'h00;
        walls[18][22] = 1'b1;
        walls[17][22] = 1'b1;
        press(8'h1A);
        do_tick(lat, nb);
        chk("up_rej_busy_cycles", nb, 5);
        chk("up_rej_dir", dir, 2'd1);
        chk("up_rej_pX", pX, 10'd286);
        chk("up_rej_pY", pY, 10'd368);
        chk("up_rej_bufvalid", dut.buf_valid_q, 1'b1);
        chk("up_rej_wq_col", wq_col, 6'd17);
        clear_walls();
        ticks(7);
        chk("up_mid_pX", pX, 10'd272);
        chk("up_mid_dir", dir, 2'd1);
        do_tick(lat, nb);
        chk("up_turn_dir", dir, 2'd0);
        chk("up_turn_pY", pY, 10'd366);
        chk("up_turn_pX", pX, 10'd272);
        chk("up_turn_busy_cycles", nb, 3);
        chk("up_turn_wq_row", wq_row, 5'd22);
        chk("up_turn_bufvalid", dut.buf_valid_q, 1'b0);

        // ---------------- tunnel wrap both ways ----------------
        do_reset();
        keycode = 8'h04;
        ticks(152);
        chk("wrap_pre_pX", pX, 10'd0);
        do_tick(lat, nb);
        chk("wrapL_pX", pX, 10'd624);
        chk("wrapL_wq_col", wq_col, 6'd39);
        chk("wrapL_wq_row", wq_row, 5'd23);
        do_tick(lat, nb);
        keycode = 8'h00;
        chk("wrapL2_pX", pX, 10'd622);
        press(8'h07);
        do_tick(lat, nb);
        chk("wrapR_pre_pX", pX, 10'd624);
        do_tick(lat, nb);
        chk("wrapR_pX", pX, 10'd0);
        chk("wrapR_wq_col", wq_col, 6'd0);
        chk("wrapR_dir", dir, 2'd3);

        // ---------------- enable low freezes, buffering continues ----------------
        enable = 1'b0;
        ticks(4);
        do_tick(lat, nb);
        chk("en0_no_busy", lat, 0);
        press(8'h16);
        chk("en0_pX", pX, 10'd0);
        chk("en0_pY", pY, 10'd368);
        chk("en0_dir", dir, 2'd3);
        enable = 1'b1;
        do_tick(lat, nb);
        chk("en1_dir", dir, 2'd2);
        chk("en1_pY", pY, 10'd370);
        chk("en1_pX", pX, 10'd0);
        chk("en1_busy_cycles", nb, 3);

        // ---------------- bottom row clamp ----------------
        ticks(47);
        chk("clamp_pre_pY", pY, 10'd464);
        do_tick(lat, nb);
        chk("clamp_pY", pY, 10'd464);
        chk("clamp_moving", moving, 1'b0);
        chk("clamp_wq_row", wq_row, 5'd29);
        chk("clamp_wq_col", wq_col, 6'd0);

        // ---------------- reset mid-update ----------------
        seen = 1'b0;
        frame_tick = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge Clk);
            if (busy) seen = 1'b1;
        end
        chk("rmid_busy_seen", seen, 1'b1);
        Reset = 1'b1;
        frame_tick = 1'b0;
        @(negedge Clk);
        chk("rmid_pX", pX, 10'd304);
        chk("rmid_pY", pY, 10'd368);
        chk("rmid_dir", dir, 2'd1);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_moving", moving, 1'b0);
        chk("rmid_wq_row", wq_row, 5'd0);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);

        // ---------------- enable falls mid-update ----------------
        seen = 1'b0;
        frame_tick = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge Clk);
            if (busy) seen = 1'b1;
        end
        chk("edrop_busy_seen", seen, 1'b1);
        enable = 1'b0;
        frame_tick = 1'b0;
        repeat (10) @(negedge Clk);
        chk("edrop_pX", pX, 10'd302);
        chk("edrop_moving", moving, 1'b1);
        do_tick(lat, nb);
        chk("edrop_no_new", lat, 0);
        chk("edrop_pX_hold", pX, 10'd302);
        enable = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
